// File: rtl/command_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : command_fetch_unit_if
// Description : Groups the decoder-RAM side and the downstream stream side of
//               the command fetch unit.
//               slave  = the fetch unit itself.
//               master = the environment (decoder, RAM, consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface command_fetch_unit_if #(
    parameter int AW = 9
);
    logic          wr_strobe;
    logic          flush;
    logic [31:0]   ram_q;
    logic [AW-1:0] read_address;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] occupancy;
    logic          empty;
    logic          full;
    logic          overflow;

    modport slave (
        input  wr_strobe, flush, ram_q, out_ready,
        output read_address, out_data, out_valid, occupancy, empty, full, overflow
    );

    modport master (
        output wr_strobe, flush, ram_q, out_ready,
        input  read_address, out_data, out_valid, occupancy, empty, full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/command_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : command_fetch_unit
// Description : Reads command words from the input-decoder RAM ring and
//               presents them downstream through a 2-entry skid FIFO that
//               absorbs the single-cycle RAM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module command_fetch_unit #(
    parameter int DEPTH = 400,
    parameter int AW    = 9
) (
    input  wire logic           clk,
    input  wire logic           n_rst,
    command_fetch_unit_if.slave bus
);

    localparam logic [AW-1:0] c_DEPTH = AW'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ONE   = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_unfetched;
    logic [AW-1:0] r_occupancy;
    logic          r_inflight;
    logic          r_overflow;
    logic [31:0]   r_skid0;
    logic [31:0]   r_skid1;
    logic [1:0]    r_skid_count;

    logic          w_full;
    logic          w_accept;
    logic          w_pop;
    logic          w_fetch;
    logic          w_capture;
    logic [2:0]    w_slots;
    logic [AW-1:0] w_wr_ptr_next;

    // Ring pointer increment with wrap from DEPTH-1 back to 0.
    function automatic logic [AW-1:0] f_ptr_inc(input logic [AW-1:0] p);
        return (p == c_LAST) ? '0 : (p + c_ONE);
    endfunction

    assign w_full        = (r_occupancy == c_DEPTH);
    assign w_accept      = bus.wr_strobe && !w_full;
    assign w_pop         = (r_skid_count != 2'd0) && bus.out_ready;
    assign w_wr_ptr_next = w_accept ? f_ptr_inc(r_wr_ptr) : r_wr_ptr;
    // Skid entries that will be committed after this edge: stored words plus
    // the word already on its way from the RAM, minus the one leaving now.
    assign w_slots       = {1'b0, r_skid_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, fetch issue and capture decisions.
    always_comb begin
        w_state_next = r_state;
        w_fetch      = 1'b0;
        w_capture    = 1'b0;

        // A flush discards whatever the RAM returns this cycle, and nothing
        // is fetched until the pointers have been realigned.
        if (!bus.flush && (r_state != S_FLUSH)) begin
            w_fetch   = (r_unfetched != '0) && (w_slots < 3'd2);
            w_capture = r_inflight;
        end

        if (bus.flush) begin
            w_state_next = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_unfetched != '0) w_state_next = S_STREAM;
                end
                S_STREAM: begin
                    if ((r_unfetched == '0) && !r_inflight) w_state_next = S_IDLE;
                end
                S_FLUSH: begin
                    w_state_next = w_accept ? S_STREAM : S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Write/read pointers, unfetched count and the in-flight marker.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_unfetched <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_inflight <= w_fetch;
            if (bus.flush) begin
                // Realign past any word the decoder writes alongside the flush.
                r_rd_ptr    <= w_wr_ptr_next;
                r_unfetched <= '0;
            end else begin
                if (w_fetch) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                case ({w_accept, w_fetch})
                    2'b10:   r_unfetched <= r_unfetched + c_ONE;
                    2'b01:   r_unfetched <= r_unfetched - c_ONE;
                    default: r_unfetched <= r_unfetched;
                endcase
            end
        end
    end

    // Occupancy counts words accepted from the decoder but not yet popped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_occupancy <= '0;
        end else if (bus.flush) begin
            r_occupancy <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occupancy <= r_occupancy + c_ONE;
                2'b01:   r_occupancy <= r_occupancy - c_ONE;
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    // Sticky overflow: a write arrived with no room; only flush clears it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_overflow <= 1'b0;
        end else if (bus.wr_strobe && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Two-entry skid FIFO; entry 0 is always the head seen downstream.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_skid0      <= '0;
            r_skid1      <= '0;
            r_skid_count <= 2'd0;
        end else if (bus.flush) begin
            r_skid_count <= 2'd0;
        end else begin
            case ({w_pop, w_capture})
                2'b01: begin
                    if (r_skid_count == 2'd0) r_skid0 <= bus.ram_q;
                    else                      r_skid1 <= bus.ram_q;
                    r_skid_count <= r_skid_count + 2'd1;
                end
                2'b10: begin
                    r_skid0      <= r_skid1;
                    r_skid_count <= r_skid_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the arriving word joins behind
                    // whatever remains after the pop.
                    if (r_skid_count == 2'd1) begin
                        r_skid0 <= bus.ram_q;
                    end else begin
                        r_skid0 <= r_skid1;
                        r_skid1 <= bus.ram_q;
                    end
                end
                default: begin
                    r_skid_count <= r_skid_count;
                end
            endcase
        end
    end

    assign bus.read_address = r_rd_ptr;
    assign bus.out_data     = r_skid0;
    assign bus.out_valid    = (r_skid_count != 2'd0);
    assign bus.occupancy    = r_occupancy;
    assign bus.empty        = (r_occupancy == '0);
    assign bus.full         = w_full;
    assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_command_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_command_fetch_unit
// Description : Self-checking bench for command_fetch_unit with a behavioural
//               decoder RAM and a queue scoreboard of expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_command_fetch_unit;

    localparam int DEPTH = 400;
    localparam int AW    = 9;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    command_fetch_unit_if #(.AW(AW)) bus ();

    command_fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    // Decoder RAM: synchronous write, one-cycle registered read.
    logic [31:0]   ram [0:DEPTH-1];
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [31:0]   ram_wd;
    always @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
        bus.ram_q <= ram[bus.read_address];
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    int          pop_cycles[$];
    int          m_occ  = 0;
    int          m_wptr = 0;
    bit          m_ovf  = 1'b0;
    int          cyc    = 0;
    logic [31:0] wdata;

    // One clock: score a pop, write the RAM, advance the model, check status.
    task automatic step();
        bit          pop;
        bit          acc;
        bit          full_m;
        logic [31:0] exp_w;
        full_m = (m_occ == DEPTH);
        pop    = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
        if (pop) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL pop_unexpected: got %h, required no word", bus.out_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (bus.out_data !== exp_w) begin
                    n_errors++;
                    $display("FAIL pop_data: got %h, required %h", bus.out_data, exp_w);
                end
            end
            pop_cycles.push_back(cyc);
        end
        acc    = bus.wr_strobe && !full_m;
        ram_we = acc;
        ram_wa = AW'(m_wptr);
        ram_wd = wdata;
        @(posedge clk);
        cyc++;
        if (bus.flush) begin
            exp_q.delete();
            m_occ = 0;
            m_ovf = 1'b0;
        end else begin
            if (acc) begin
                exp_q.push_back(wdata);
                m_occ++;
            end
            if (pop) m_occ--;
            if (bus.wr_strobe && full_m) m_ovf = 1'b1;
        end
        if (acc) m_wptr = (m_wptr + 1) % DEPTH;
        @(negedge clk);
        ram_we = 1'b0;
        n_checks++;
        if (bus.occupancy !== AW'(m_occ) || bus.empty !== (m_occ == 0) ||
            bus.full !== (m_occ == DEPTH) || bus.overflow !== m_ovf) begin
            n_errors++;
            $display("FAIL status: occ=%0d empty=%b full=%b ovf=%b, required occ=%0d empty=%b full=%b ovf=%b",
                     bus.occupancy, bus.empty, bus.full, bus.overflow,
                     m_occ, (m_occ == 0), (m_occ == DEPTH), m_ovf);
        end
    endtask

    task automatic drive(input bit wr, input logic [31:0] d, input bit rdy, input bit fl);
        bus.wr_strobe = wr;
        wdata         = d;
        bus.out_ready = rdy;
        bus.flush     = fl;
        step();
        bus.wr_strobe = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && n < budget) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        n_checks++;
        if ({bus.read_address, bus.out_valid, bus.out_data, bus.occupancy, bus.empty, bus.full, bus.overflow}
            !== {9'd0, 1'b0, 32'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: addr=%0d valid=%b data=%h occ=%0d empty=%b full=%b ovf=%b, required 0 0 0 0 1 0 0",
                     bus.read_address, bus.out_valid, bus.out_data, bus.occupancy, bus.empty, bus.full, bus.overflow);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_lat1: out_valid=%b, required 0", bus.out_valid);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_lat2: out_valid=%b, required 0", bus.out_valid);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5_0001) begin
            n_errors++;
            $display("FAIL single_out: valid=%b data=%h, required 1 a5a50001", bus.out_valid, bus.out_data);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (bus.occupancy !== '0 || bus.empty !== 1'b1) begin
            n_errors++;
            $display("FAIL single_after: occ=%0d empty=%b, required 0 1", bus.occupancy, bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        pop_cycles.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, 32'hB000_0000 + i, 1'b1, 1'b0);
        drain(20);
        n_checks++;
        if (pop_cycles.size() != 8) begin
            n_errors++; $display("FAIL b2b_count: %0d pops, required 8", pop_cycles.size());
        end else if (pop_cycles[7] - pop_cycles[0] != 7) begin
            n_errors++; $display("FAIL b2b_rate: span %0d cycles, required 7", pop_cycles[7] - pop_cycles[0]);
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0);
        n_checks++;
        if (bus.full !== 1'b1 || bus.occupancy !== AW'(DEPTH)) begin
            n_errors++; $display("FAIL full: full=%b occ=%0d, required 1 400", bus.full, bus.occupancy);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hF000_0000) begin
            n_errors++; $display("FAIL hold: valid=%b data=%h, required 1 f0000000", bus.out_valid, bus.out_data);
        end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.occupancy !== AW'(DEPTH)) begin
            n_errors++; $display("FAIL overflow: ovf=%b occ=%0d, required 1 400", bus.overflow, bus.occupancy);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== '0 || bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL full_flush: valid=%b occ=%0d ovf=%b, required 0 0 0", bus.out_valid, bus.occupancy, bus.overflow);
        end
    endtask

    task automatic test_wrap();
        int          guard;
        logic [AW-1:0] addr_seen[$];
        int          exp_addr[4];
        guard = 0;
        while (m_wptr != DEPTH - 1 && guard < DEPTH) begin
            drive(1'b1, 32'h5000_0000 + guard, 1'b1, 1'b0);
            guard++;
        end
        drain(20);
        n_checks++;
        if (bus.read_address !== AW'(DEPTH - 1)) begin
            n_errors++; $display("FAIL wrap_start: addr=%0d, required 399", bus.read_address);
        end
        exp_addr = '{DEPTH - 1, 0, 1, 2};
        addr_seen.push_back(bus.read_address);
        for (int i = 0; i < 12; i++) begin
            drive(i < 3, 32'h7000_0000 + i, 1'b1, 1'b0);
            if (bus.read_address !== addr_seen[addr_seen.size() - 1]) addr_seen.push_back(bus.read_address);
        end
        n_checks++;
        if (addr_seen.size() != 4) begin
            n_errors++; $display("FAIL wrap_addr_count: %0d addresses, required 4", addr_seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (addr_seen[i] !== AW'(exp_addr[i])) begin
                    n_errors++; $display("FAIL wrap_addr%0d: got %0d, required %0d", i, addr_seen[i], exp_addr[i]);
                end
            end
        end
        drain(10);
    endtask

    task automatic test_flush_inflight();
        for (int i = 0; i < 6; i++) drive(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'hBAD0_0000, 1'b0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== '0) begin
            n_errors++; $display("FAIL flush_now: valid=%b occ=%0d, required 0 0", bus.out_valid, bus.occupancy);
        end
        pop_cycles.delete();
        drive(1'b1, 32'hC0DE_0001, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_next: valid=%b, required 0", bus.out_valid);
        end
        drain(10);
        n_checks++;
        if (pop_cycles.size() != 1) begin
            n_errors++; $display("FAIL flush_stream: %0d pops, required 1", pop_cycles.size());
        end
    endtask

    task automatic test_reset_midstream();
        int n;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hE000_0000 + i, 1'b0, 1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_errors++; $display("FAIL mid_valid: valid=%b, required 1", bus.out_valid);
        end
        #2 n_rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({bus.read_address, bus.out_valid, bus.out_data, bus.occupancy, bus.empty, bus.full, bus.overflow}
                !== {9'd0, 1'b0, 32'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL mid_reset%0d: addr=%0d valid=%b data=%h occ=%0d empty=%b full=%b ovf=%b, required 0 0 0 0 1 0 0",
                         k, bus.read_address, bus.out_valid, bus.out_data, bus.occupancy, bus.empty, bus.full, bus.overflow);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.delete();
        m_occ  = 0;
        m_wptr = 0;
        m_ovf  = 1'b0;
        drive(1'b1, 32'h600D_0001, 1'b1, 1'b0);
        drain(10);
    endtask

    initial begin
        bus.wr_strobe = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        ram_we        = 1'b0;
        ram_wa        = '0;
        ram_wd        = '0;
        wdata         = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_overflow();
        test_wrap();
        test_flush_inflight();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
